// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio DAC serializer.
package audio_pkg;

  localparam int SAMPLE_W   = 16;  // bits per channel sample
  localparam int FIFO_DEPTH = 4;   // stereo frames buffered, power of two

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dac_state_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo frame stream into the serializer.
// Handshake: a frame moves on every rising clk edge where in_valid && in_ready
// are both high; the master holds in_data stable while in_valid is high, and
// in_ready never depends on in_valid.
interface audio_dac_serializer_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sample_fifo.sv
// Frame FIFO: synchronous write, head visible at rd_data, pointers carry one
// wrap bit so full and empty are told apart without a separate counter.
module sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  // A write while full is only allowed when the head leaves in the same cycle.
  assign do_wr   = wr_en & (~full | rd_en);
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers stereo frames and shifts them out MSB first,
// paced by the codec's BCLK/DACLRCK which are sampled into the Clk domain.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = audio_pkg::FIFO_DEPTH
) (
  input  logic                         Clk,
  input  logic                         reset,
  audio_dac_serializer_if.slave        in_s,
  input  logic                         AUD_BCLK,
  input  logic                         AUD_DACLRCK,
  output logic                         AUD_DACDAT,
  output logic                         Send_Done,
  output logic                         underrun,
  output dac_state_t                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]  dbg_level
);
  localparam int CW = $clog2(SAMPLE_W + 1);

  // [0],[1] form the synchronizer, [2] is the edge-detect register.
  logic [2:0]            bclk_sr;
  logic [2:0]            lrck_sr;
  logic                  bclk_fall, lrck_fall, lrck_rise, lrck_edge;

  logic                  fifo_full, fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_rd_data;
  logic                  push, pop;

  dac_state_t            state, state_nx;
  logic [SAMPLE_W-1:0]   right_word;   // right sample of the current frame
  logic [SAMPLE_W-1:0]   shifter;      // channel word being sent, MSB at top
  logic [CW-1:0]         bit_cnt;
  logic                  dacdat_q, send_done_q, underrun_q;
  logic                  bit_tick, done_hit;

  // Bring the codec clocks into the Clk domain.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], AUD_BCLK};
      lrck_sr <= {lrck_sr[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = bclk_sr[2] & ~bclk_sr[1];
  assign lrck_fall = lrck_sr[2] & ~lrck_sr[1];
  assign lrck_rise = ~lrck_sr[2] & lrck_sr[1];
  assign lrck_edge = lrck_fall | lrck_rise;

  // Every word-clock falling edge starts a frame and consumes the FIFO head.
  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign pop           = lrck_fall & ~fifo_empty;
  assign in_s.in_ready = ~fifo_full | pop;
  assign push          = in_s.in_valid & in_s.in_ready;

  sample_fifo #(
    .W     (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (reset),
    .wr_en   (push),
    .wr_data (in_s.in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (dbg_level)
  );

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Channel sequencing follows the word clock.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (lrck_fall) state_nx = LEFT;
      LEFT:    if (lrck_rise) state_nx = RIGHT;
      RIGHT:   if (lrck_fall) state_nx = LEFT;
      default: state_nx = IDLE;
    endcase
  end

  // A word-clock edge wins over a coincident BCLK edge: no bit that cycle.
  assign bit_tick = bclk_fall & ~lrck_edge & (state != IDLE);
  assign done_hit = bit_tick & (state == RIGHT) & (bit_cnt == CW'(SAMPLE_W - 1));

  // Load words on word-clock edges and shift one bit per BCLK falling edge.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      right_word  <= '0;
      shifter     <= '0;
      bit_cnt     <= '0;
      dacdat_q    <= 1'b0;
      send_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      send_done_q <= done_hit;
      underrun_q  <= lrck_fall & fifo_empty;
      if (lrck_fall) begin
        shifter    <= pop ? fifo_rd_data[2*SAMPLE_W-1:SAMPLE_W] : '0;
        right_word <= pop ? fifo_rd_data[SAMPLE_W-1:0] : '0;
        bit_cnt    <= '0;
      end else if (lrck_rise) begin
        shifter <= right_word;
        bit_cnt <= '0;
      end else if (bit_tick) begin
        if (bit_cnt < CW'(SAMPLE_W)) begin
          dacdat_q <= shifter[SAMPLE_W-1];
          shifter  <= {shifter[SAMPLE_W-2:0], 1'b0};
          bit_cnt  <= bit_cnt + CW'(1);
        end else begin
          dacdat_q <= 1'b0;
        end
      end
    end
  end

  assign AUD_DACDAT = dacdat_q;
  assign Send_Done  = send_done_q;
  assign underrun   = underrun_q;
  assign dbg_state  = state;

endmodule
